// File: rtl/wb_interconnect_nport_if.sv
// Wishbone bundle for the 1-master / N-slave interconnect.
// Holds both the upstream master bus and the fanned-out slave bus.
// Modports: ic (the interconnect itself), master (upstream bus master),
// slave (the collection of downstream slaves).
interface wb_interconnect_nport_if #(
  parameter int NUM_SLAVES = 4,
  parameter int DW         = 32,
  parameter int SLV_AW     = 9
);
  // upstream master side
  logic                     m_wb_cyc_i;
  logic                     m_wb_stb_i;
  logic                     m_wb_we_i;
  logic [31:0]              m_wb_adr_i;
  logic [DW/8-1:0]          m_wb_sel_i;
  logic [DW-1:0]            m_wb_dat_i;
  logic [DW-1:0]            m_wb_dat_o;
  logic                     m_wb_ack_o;
  logic                     m_wb_err_o;
  // downstream slave side
  logic [NUM_SLAVES-1:0]    s_wb_cyc_o;
  logic [NUM_SLAVES-1:0]    s_wb_stb_o;
  logic                     s_wb_we_o;
  logic [SLV_AW-1:0]        s_wb_adr_o;
  logic [DW/8-1:0]          s_wb_sel_o;
  logic [DW-1:0]            s_wb_dat_o;
  logic [NUM_SLAVES*DW-1:0] s_wb_dat_i;
  logic [NUM_SLAVES-1:0]    s_wb_ack_i;

  modport ic (
    input  m_wb_cyc_i, m_wb_stb_i, m_wb_we_i, m_wb_adr_i, m_wb_sel_i, m_wb_dat_i,
    output m_wb_dat_o, m_wb_ack_o, m_wb_err_o,
    output s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, s_wb_adr_o, s_wb_sel_o, s_wb_dat_o,
    input  s_wb_dat_i, s_wb_ack_i
  );

  modport master (
    output m_wb_cyc_i, m_wb_stb_i, m_wb_we_i, m_wb_adr_i, m_wb_sel_i, m_wb_dat_i,
    input  m_wb_dat_o, m_wb_ack_o, m_wb_err_o
  );

  modport slave (
    input  s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, s_wb_adr_o, s_wb_sel_o, s_wb_dat_o,
    output s_wb_dat_i, s_wb_ack_i
  );
endinterface

// File: rtl/wb_interconnect_nport.sv
// 1-master / N-slave classic Wishbone interconnect (single beat).
// Decodes the slave index from m_wb_adr_i[SEL_LSB +: SEL_W], owns each
// transaction to completion and answers decode misses and slave timeouts
// with an error response carrying ERR_DATA.
// Optional error log: define WB_IC_ERRLOG_EN to add err_cnt_o/err_adr_o/err_to_o.
module wb_interconnect_nport #(
  parameter int              NUM_SLAVES = 4,
  parameter int              DW         = 32,
  parameter int              SEL_LSB    = 8,
  parameter int              SEL_W      = 4,
  parameter int              SLV_AW     = 9,
  parameter int              TIMEOUT    = 255,
  parameter logic [DW-1:0]   ERR_DATA   = DW'(32'hBADC0DE0)
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  wb_interconnect_nport_if.ic    bus
`ifdef WB_IC_ERRLOG_EN
  ,
  output logic [15:0]            err_cnt_o,
  output logic [31:0]            err_adr_o,
  output logic                   err_to_o
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

  localparam logic [SEL_W:0] NS_W = (SEL_W+1)'(NUM_SLAVES);
  localparam logic [15:0]    TO_W = 16'(TIMEOUT);

  state_t                r_state;
  logic [NUM_SLAVES-1:0] r_s_cyc;
  logic [NUM_SLAVES-1:0] r_s_stb;
  logic                  r_s_we;
  logic [SLV_AW-1:0]     r_s_adr;
  logic [DW/8-1:0]       r_s_sel;
  logic [DW-1:0]         r_s_dat;
  logic [DW-1:0]         r_m_dat;
  logic                  r_m_ack;
  logic                  r_m_err;
  logic [15:0]           r_cnt;

  logic [SEL_W-1:0]      w_req_idx;
  logic                  w_hit;
  logic [NUM_SLAVES-1:0] w_req_onehot;
  logic                  w_idle_req;
  logic                  w_decode_miss;
  logic                  w_slv_ack;
  logic [DW-1:0]         w_slv_dat_masked [NUM_SLAVES];
  logic [DW-1:0]         w_slv_dat;
  logic [15:0]           w_cnt_next;
  logic                  w_timeout;
  logic                  w_to_err;
  logic                  w_unused_adr;

  // address decode of the incoming request
  assign w_req_idx     = bus.m_wb_adr_i[SEL_LSB +: SEL_W];
  assign w_hit         = ({1'b0, w_req_idx} < NS_W);
  assign w_idle_req    = (r_state == ST_IDLE) && bus.m_wb_cyc_i && bus.m_wb_stb_i;
  assign w_decode_miss = w_idle_req && !w_hit;

  // only the slave currently strobed may complete or return data, so any
  // ack or data from the other ports is masked off here
  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slv
      assign w_req_onehot[gi]     = (w_req_idx == SEL_W'(gi));
      assign w_slv_dat_masked[gi] = r_s_stb[gi] ? bus.s_wb_dat_i[gi*DW +: DW] : '0;
    end
  endgenerate

  assign w_slv_ack = |(bus.s_wb_ack_i & r_s_stb);

  // OR-combine the masked slave read data (at most one slice is non-zero)
  always_comb begin
    w_slv_dat = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      w_slv_dat = w_slv_dat | w_slv_dat_masked[k];
    end
  end

  // timeout fires at the end of the TIMEOUT-th ACCESS cycle; an ack in the
  // same cycle takes priority, and an abort takes priority over both
  assign w_cnt_next = r_cnt + 16'd1;
  assign w_timeout  = (w_cnt_next == TO_W);
  assign w_to_err   = (r_state == ST_ACCESS) && bus.m_wb_cyc_i && !w_slv_ack && w_timeout;

  // upper / unforwarded address bits are intentionally ignored by the datapath
  assign w_unused_adr = &{1'b0, bus.m_wb_adr_i};

  // transaction FSM with all bus outputs registered
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= ST_IDLE;
      r_s_cyc <= '0;
      r_s_stb <= '0;
      r_s_we  <= 1'b0;
      r_s_adr <= '0;
      r_s_sel <= '0;
      r_s_dat <= '0;
      r_m_dat <= '0;
      r_m_ack <= 1'b0;
      r_m_err <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_m_ack <= 1'b0;
      r_m_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_m_dat <= '0;
          if (w_idle_req) begin
            r_s_we  <= bus.m_wb_we_i;
            r_s_adr <= bus.m_wb_adr_i[SLV_AW-1:0];
            r_s_sel <= bus.m_wb_sel_i;
            r_s_dat <= bus.m_wb_dat_i;
            r_cnt   <= '0;
            if (w_hit) begin
              r_s_cyc <= w_req_onehot;
              r_s_stb <= w_req_onehot;
              r_state <= ST_ACCESS;
            end else begin
              r_m_ack <= 1'b1;
              r_m_err <= 1'b1;
              r_m_dat <= ERR_DATA;
              r_state <= ST_RESP;
            end
          end
        end
        ST_ACCESS: begin
          if (!bus.m_wb_cyc_i) begin
            // master abandoned the cycle: release the slave, no response
            r_s_cyc <= '0;
            r_s_stb <= '0;
            r_state <= ST_IDLE;
          end else if (w_slv_ack) begin
            r_s_cyc <= '0;
            r_s_stb <= '0;
            r_m_ack <= 1'b1;
            r_m_dat <= r_s_we ? '0 : w_slv_dat;
            r_state <= ST_RESP;
          end else if (w_timeout) begin
            r_s_cyc <= '0;
            r_s_stb <= '0;
            r_m_ack <= 1'b1;
            r_m_err <= 1'b1;
            r_m_dat <= ERR_DATA;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        ST_RESP: begin
          r_m_dat <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_s_cyc <= '0;
          r_s_stb <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.m_wb_dat_o = r_m_dat;
  assign bus.m_wb_ack_o = r_m_ack;
  assign bus.m_wb_err_o = r_m_err;
  assign bus.s_wb_cyc_o = r_s_cyc;
  assign bus.s_wb_stb_o = r_s_stb;
  assign bus.s_wb_we_o  = r_s_we;
  assign bus.s_wb_adr_o = r_s_adr;
  assign bus.s_wb_sel_o = r_s_sel;
  assign bus.s_wb_dat_o = r_s_dat;

`ifdef WB_IC_ERRLOG_EN
  logic [31:0] r_req_adr;
  logic [15:0] r_err_cnt;
  logic [31:0] r_err_adr;
  logic        r_err_to;

  // error log: full request address is kept so a timeout can be attributed
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_req_adr <= '0;
      r_err_cnt <= '0;
      r_err_adr <= '0;
      r_err_to  <= 1'b0;
    end else begin
      if (w_idle_req) begin
        r_req_adr <= bus.m_wb_adr_i;
      end
      if (w_decode_miss) begin
        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        r_err_adr <= bus.m_wb_adr_i;
        r_err_to  <= 1'b0;
      end else if (w_to_err) begin
        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        r_err_adr <= r_req_adr;
        r_err_to  <= 1'b1;
      end
    end
  end

  assign err_cnt_o = r_err_cnt;
  assign err_adr_o = r_err_adr;
  assign err_to_o  = r_err_to;
`else
  logic w_unused_err;
  assign w_unused_err = &{1'b0, w_decode_miss, w_to_err};
`endif

endmodule

// File: tb/tb_wb_interconnect_nport.sv
// Directed bench for wb_interconnect_nport (NUM_SLAVES=4, DW=32, TIMEOUT=255).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_wb_interconnect_nport;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   held;

  wb_interconnect_nport_if #(.NUM_SLAVES(4), .DW(32), .SLV_AW(9)) bus_if ();

`ifdef WB_IC_ERRLOG_EN
  logic [15:0] err_cnt;
  logic [31:0] err_adr;
  logic        err_to;
`endif

  wb_interconnect_nport dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus_if)
`ifdef WB_IC_ERRLOG_EN
    ,
    .err_cnt_o (err_cnt),
    .err_adr_o (err_adr),
    .err_to_o  (err_to)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                     input logic [31:0] dat);
    bus_if.m_wb_cyc_i = 1'b1;
    bus_if.m_wb_stb_i = 1'b1;
    bus_if.m_wb_we_i  = we;
    bus_if.m_wb_adr_i = adr;
    bus_if.m_wb_sel_i = sel;
    bus_if.m_wb_dat_i = dat;
    $display("req we=%0d adr=%h sel=%b dat=%h at t=%0t", we, adr, sel, dat, $time);
  endtask

  task automatic drop();
    bus_if.m_wb_cyc_i = 1'b0;
    bus_if.m_wb_stb_i = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus_if.m_wb_cyc_i = 1'b0;
    bus_if.m_wb_stb_i = 1'b0;
    bus_if.m_wb_we_i  = 1'b0;
    bus_if.m_wb_adr_i = '0;
    bus_if.m_wb_sel_i = '0;
    bus_if.m_wb_dat_i = '0;
    bus_if.s_wb_dat_i = '0;
    bus_if.s_wb_ack_i = '0;

    // reset state
    nxt(); nxt();
    chk("rst_m_ack", 32'(bus_if.m_wb_ack_o), 32'd0);
    chk("rst_m_err", 32'(bus_if.m_wb_err_o), 32'd0);
    chk("rst_m_dat", bus_if.m_wb_dat_o, 32'd0);
    chk("rst_s_cyc", 32'(bus_if.s_wb_cyc_o), 32'd0);
    chk("rst_s_stb", 32'(bus_if.s_wb_stb_o), 32'd0);
`ifdef WB_IC_ERRLOG_EN
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    nxt();

    // read slave 1, ack 3 cycles late, stray ack from slave 0 in between
    req(1'b0, 32'h0000_0104, 4'hF, 32'h0);
    nxt(); // cycle 1
    chk("rd_s_stb", 32'(bus_if.s_wb_stb_o), 32'h2);
    chk("rd_s_cyc", 32'(bus_if.s_wb_cyc_o), 32'h2);
    chk("rd_s_adr", 32'(bus_if.s_wb_adr_o), 32'h104);
    chk("rd_s_we",  32'(bus_if.s_wb_we_o), 32'd0);
    nxt(); // cycle 2
    bus_if.s_wb_ack_i = 4'b0001;
    bus_if.s_wb_dat_i[0 +: 32] = 32'hDEAD_BEEF;
    chk("rd_c2_ack", 32'(bus_if.m_wb_ack_o), 32'd0);
    nxt(); // cycle 3
    bus_if.s_wb_ack_i = 4'b0000;
    chk("stray_stb", 32'(bus_if.s_wb_stb_o), 32'h2);
    chk("stray_ack", 32'(bus_if.m_wb_ack_o), 32'd0);
    nxt(); // cycle 4
    bus_if.s_wb_ack_i = 4'b0010;
    bus_if.s_wb_dat_i[32 +: 32] = 32'h1234_5678;
    chk("rd_c4_ack", 32'(bus_if.m_wb_ack_o), 32'd0);
    nxt(); // cycle 5
    bus_if.s_wb_ack_i = 4'b0000;
    chk("rd_m_ack", 32'(bus_if.m_wb_ack_o), 32'd1);
    chk("rd_m_dat", bus_if.m_wb_dat_o, 32'h1234_5678);
    chk("rd_m_err", 32'(bus_if.m_wb_err_o), 32'd0);
    chk("rd_s_stb_off", 32'(bus_if.s_wb_stb_o), 32'd0);
    drop();
    $display("read slave1 dat=%h at t=%0t", bus_if.m_wb_dat_o, $time);
    nxt(); // cycle 6
    chk("rd_ack_single", 32'(bus_if.m_wb_ack_o), 32'd0);

    // zero-wait write to slave 3
    req(1'b1, 32'h0000_0300, 4'b0011, 32'hA5A5_A5A5);
    nxt(); // cycle 1
    chk("wr_s_stb", 32'(bus_if.s_wb_stb_o), 32'h8);
    chk("wr_s_we",  32'(bus_if.s_wb_we_o), 32'd1);
    chk("wr_s_dat", bus_if.s_wb_dat_o, 32'hA5A5_A5A5);
    chk("wr_s_sel", 32'(bus_if.s_wb_sel_o), 32'h3);
    chk("wr_s_adr", 32'(bus_if.s_wb_adr_o), 32'h100);
    bus_if.s_wb_ack_i = 4'b1000;
    nxt(); // cycle 2
    bus_if.s_wb_ack_i = 4'b0000;
    chk("wr_m_ack", 32'(bus_if.m_wb_ack_o), 32'd1);
    chk("wr_m_err", 32'(bus_if.m_wb_err_o), 32'd0);
    chk("wr_m_dat", bus_if.m_wb_dat_o, 32'd0);
    drop();
    $display("write slave3 acked at t=%0t", $time);
    nxt();

    // decode miss
    req(1'b0, 32'h0000_0F00, 4'hF, 32'h0);
    nxt(); // cycle 1
    chk("miss_m_ack", 32'(bus_if.m_wb_ack_o), 32'd1);
    chk("miss_m_err", 32'(bus_if.m_wb_err_o), 32'd1);
    chk("miss_m_dat", bus_if.m_wb_dat_o, 32'hBADC_0DE0);
    chk("miss_s_stb", 32'(bus_if.s_wb_stb_o), 32'd0);
`ifdef WB_IC_ERRLOG_EN
    chk("miss_err_cnt", 32'(err_cnt), 32'd1);
    chk("miss_err_adr", err_adr, 32'h0000_0F00);
    chk("miss_err_to",  32'(err_to), 32'd0);
`endif
    drop();
    $display("decode miss err=%0d at t=%0t", bus_if.m_wb_err_o, $time);
    nxt();
    chk("miss_ack_single", 32'(bus_if.m_wb_ack_o), 32'd0);

    // timeout on slave 2
    req(1'b0, 32'h0000_0200, 4'hF, 32'h0);
    held = 0;
    for (int i = 1; i <= 255; i++) begin
      nxt();
      if (bus_if.s_wb_stb_o == 4'b0100 && bus_if.m_wb_ack_o == 1'b0) held++;
    end
    chk("to_hold", 32'(held), 32'd255);
    nxt(); // cycle 256
    chk("to_m_ack", 32'(bus_if.m_wb_ack_o), 32'd1);
    chk("to_m_err", 32'(bus_if.m_wb_err_o), 32'd1);
    chk("to_m_dat", bus_if.m_wb_dat_o, 32'hBADC_0DE0);
    chk("to_s_stb", 32'(bus_if.s_wb_stb_o), 32'd0);
`ifdef WB_IC_ERRLOG_EN
    chk("to_err_cnt", 32'(err_cnt), 32'd2);
    chk("to_err_adr", err_adr, 32'h0000_0200);
    chk("to_err_to",  32'(err_to), 32'd1);
`endif
    drop();
    $display("timeout slave2 err=%0d at t=%0t", bus_if.m_wb_err_o, $time);
    nxt();

    // ack in the very cycle the timeout would fire: normal response wins
    req(1'b0, 32'h0000_0208, 4'hF, 32'h0);
    for (int i = 1; i <= 255; i++) nxt();
    bus_if.s_wb_ack_i = 4'b0100;
    bus_if.s_wb_dat_i[64 +: 32] = 32'h0BAD_F00D;
    nxt(); // cycle 256
    bus_if.s_wb_ack_i = 4'b0000;
    chk("tolast_m_ack", 32'(bus_if.m_wb_ack_o), 32'd1);
    chk("tolast_m_err", 32'(bus_if.m_wb_err_o), 32'd0);
    chk("tolast_m_dat", bus_if.m_wb_dat_o, 32'h0BAD_F00D);
    drop();
    $display("late ack slave2 dat=%h at t=%0t", bus_if.m_wb_dat_o, $time);
    nxt();

    // abort while slave 0 pending, then a normal read of slave 3
    req(1'b0, 32'h0000_0010, 4'hF, 32'h0);
    nxt(); // cycle 1
    chk("ab_s_cyc", 32'(bus_if.s_wb_cyc_o), 32'h1);
    drop();
    nxt(); // cycle 2
    chk("ab_s_cyc_off", 32'(bus_if.s_wb_cyc_o), 32'd0);
    chk("ab_s_stb_off", 32'(bus_if.s_wb_stb_o), 32'd0);
    chk("ab_m_ack", 32'(bus_if.m_wb_ack_o), 32'd0);
    nxt();
    chk("ab_m_ack2", 32'(bus_if.m_wb_ack_o), 32'd0);
    $display("abort slave0 at t=%0t", $time);
    req(1'b0, 32'h0000_03FC, 4'hF, 32'h0);
    nxt(); // cycle 1
    chk("post_ab_s_stb", 32'(bus_if.s_wb_stb_o), 32'h8);
    chk("post_ab_s_adr", 32'(bus_if.s_wb_adr_o), 32'h1FC);
    bus_if.s_wb_ack_i = 4'b1000;
    bus_if.s_wb_dat_i[96 +: 32] = 32'hCAFE_F00D;
    nxt(); // cycle 2
    bus_if.s_wb_ack_i = 4'b0000;
    chk("post_ab_m_ack", 32'(bus_if.m_wb_ack_o), 32'd1);
    chk("post_ab_m_dat", bus_if.m_wb_dat_o, 32'hCAFE_F00D);
    drop();
    $display("read slave3 dat=%h at t=%0t", bus_if.m_wb_dat_o, $time);
    nxt();

    // async reset in the middle of an ACCESS
    req(1'b1, 32'h0000_0100, 4'hF, 32'h1111_2222);
    nxt(); // cycle 1
    chk("rs_s_stb", 32'(bus_if.s_wb_stb_o), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_s_cyc", 32'(bus_if.s_wb_cyc_o), 32'd0);
    chk("rs_s_stb0", 32'(bus_if.s_wb_stb_o), 32'd0);
    chk("rs_s_we", 32'(bus_if.s_wb_we_o), 32'd0);
    chk("rs_s_adr", 32'(bus_if.s_wb_adr_o), 32'd0);
    chk("rs_s_dat", bus_if.s_wb_dat_o, 32'd0);
    chk("rs_m_ack", 32'(bus_if.m_wb_ack_o), 32'd0);
`ifdef WB_IC_ERRLOG_EN
    chk("rs_err_cnt", 32'(err_cnt), 32'd0);
`endif
    drop();
    $display("async reset mid-access at t=%0t", $time);
    nxt();
    rst_n = 1'b1;
    nxt();

    // decode miss after reset still answered
    req(1'b0, 32'h0000_0500, 4'hF, 32'h0);
    nxt();
    chk("rs_miss_ack", 32'(bus_if.m_wb_ack_o), 32'd1);
    chk("rs_miss_err", 32'(bus_if.m_wb_err_o), 32'd1);
    drop();
    $display("decode miss after reset at t=%0t", $time);
    nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
